// File: rtl/cam_pixel_packer.sv
// Packs an 8-bit CMOS camera byte stream (RGB565, high byte first) into 16-bit FIFO writes.
// Optional CAM_PACK_STATS_EN adds frame_cnt / line_err statistics outputs.
module cam_pixel_packer #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_db,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        overflow,
`ifdef CAM_PACK_STATS_EN
  output logic [15:0] frame_cnt,
  output logic        line_err,
`endif
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int RW = $clog2(V_LINES + 1);

  typedef enum logic [1:0] {
    WAIT_VS_HIGH = 2'd0,
    WAIT_VS_LOW  = 2'd1,
    CAPTURE      = 2'd2
  } state_t;

  state_t        state;
  logic          vs_r;
  logic          href_r;
  logic          href_d;
  logic [7:0]    db_r;
  logic [7:0]    hi_byte;
  logic          phase;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
`ifdef CAM_PACK_STATS_EN
  // Overrun bits distinguish "exactly H/V" from "more than H/V" once counters saturate.
  logic          col_ovr;
  logic          row_ovr;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_VS_HIGH;
      vs_r        <= 1'b0;
      href_r      <= 1'b0;
      href_d      <= 1'b0;
      db_r        <= 8'd0;
      hi_byte     <= 8'd0;
      phase       <= 1'b0;
      col         <= '0;
      row         <= '0;
      wr_en       <= 1'b0;
      wr_data     <= 16'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
`ifdef CAM_PACK_STATS_EN
      col_ovr     <= 1'b0;
      row_ovr     <= 1'b0;
      frame_cnt   <= 16'd0;
      line_err    <= 1'b0;
`endif
    end else begin
      vs_r        <= cmos_vsync;
      href_r      <= cmos_href;
      db_r        <= cmos_db;
      href_d      <= href_r;
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        WAIT_VS_HIGH: begin
          phase <= 1'b0;
          if (vs_r) state <= WAIT_VS_LOW;
        end
        WAIT_VS_LOW: begin
          phase <= 1'b0;
          if (!vs_r) begin
            state       <= CAPTURE;
            frame_start <= 1'b1;
            col         <= '0;
            row         <= '0;
`ifdef CAM_PACK_STATS_EN
            col_ovr     <= 1'b0;
            row_ovr     <= 1'b0;
`endif
          end
        end
        CAPTURE: begin
          if (vs_r) begin
            state      <= WAIT_VS_LOW;
            phase      <= 1'b0;
            frame_done <= 1'b1;
`ifdef CAM_PACK_STATS_EN
            frame_cnt  <= frame_cnt + 16'd1;
            if (row != RW'(V_LINES) || row_ovr) line_err <= 1'b1;
`endif
          end else if (href_d && !href_r) begin
            // Line end: drop any unpaired byte and advance to the next row.
            phase <= 1'b0;
            col   <= '0;
`ifdef CAM_PACK_STATS_EN
            col_ovr <= 1'b0;
            if (row < RW'(V_LINES) && (col != CW'(H_PIXELS) || col_ovr)) line_err <= 1'b1;
            if (row == RW'(V_LINES)) row_ovr <= 1'b1;
`endif
            if (row < RW'(V_LINES)) row <= row + 1'b1;
          end else if (href_r) begin
            if (!phase) begin
              hi_byte <= db_r;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (row < RW'(V_LINES)) begin
                if (col < CW'(H_PIXELS)) begin
                  col <= col + 1'b1;
                  if (fifo_full) begin
                    overflow <= 1'b1;
                  end else begin
                    wr_en   <= 1'b1;
                    wr_data <= {hi_byte, db_r};
                  end
                end
`ifdef CAM_PACK_STATS_EN
                else col_ovr <= 1'b1;
`endif
              end
            end
          end
        end
        default: state <= WAIT_VS_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer: byte-level camera driver, scoreboard queue of packed pixels.
// Build with CAM_PACK_STATS_EN defined to also exercise the statistics outputs.
module tb_cam_pixel_packer;
  localparam int H = 4;
  localparam int V = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_db = 8'd0;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        frame_start;
  logic        frame_done;
  logic        overflow;
  logic [1:0]  state_dbg;
`ifdef CAM_PACK_STATS_EN
  logic [15:0] frame_cnt;
  logic        line_err;
`endif

  cam_pixel_packer #(.H_PIXELS(H), .V_LINES(V)) dut (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_db(cmos_db), .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
    .frame_start(frame_start), .frame_done(frame_done), .overflow(overflow),
`ifdef CAM_PACK_STATS_EN
    .frame_cnt(frame_cnt), .line_err(line_err),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  logic [7:0]  lb[$];
  int total = 0;
  int bad = 0;
  int n_wr = 0;
  int n_fs = 0;
  int n_fd = 0;
  int m_row = 0;
  logic m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write must match the oldest expected pixel.
  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) check("unexpected_wr", {16'd0, wr_data}, 32'hDEAD_BEEF);
      else check("wr_data", {16'd0, wr_data}, {16'd0, exp_q.pop_front()});
    end
    if (frame_start) n_fs++;
    if (frame_done) n_fd++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    @(posedge clk); #1; cmos_vsync = 1'b1;
    tick(3);
    cmos_vsync = 1'b0;
    tick(3);
    m_row = 0;
  endtask

  task automatic frame_end();
    @(posedge clk); #1; cmos_vsync = 1'b1;
    tick(4);
  endtask

  task automatic rand_bytes(input int n);
    for (int i = 0; i < n; i++) lb.push_back(8'($urandom_range(0, 255)));
  endtask

  // Drives lb[] as one href line; fifo_full changes with each low byte for pixels >= full_pix.
  task automatic send_line(input bit live, input int full_pix);
    int n;
    int k;
    n = lb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i % 2 == 1) fifo_full = ((i / 2) >= full_pix);
      cmos_href = 1'b1;
      cmos_db   = lb[i];
      if (live && (i % 2 == 1)) begin
        k = i / 2;
        if (m_row < V && k < H) begin
          if (k >= full_pix) m_ovf = 1'b1;
          else exp_q.push_back({lb[i-1], lb[i]});
        end
      end
    end
    @(posedge clk); #1; cmos_href = 1'b0;
    tick(4);
    if (live) m_row++;
    lb.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_ovf = 1'b0;
    tick(1);
  endtask

  int base;

  initial begin
    #1;
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    tick(2);
    rst = 1'b0;

    // Mid-frame start: href activity with vsync low after reset must not be captured.
    base = n_wr;
    rand_bytes(8); send_line(1'b0, 999);
    rand_bytes(8); send_line(1'b0, 999);
    check("no_capture_before_vsync", n_wr - base, 0);
    check("no_frame_start_before_vsync", n_fs, 0);

    // Basic frame: two pixels 0xF800, 0x07E0.
    frame_begin();
    check("frame_start_once", n_fs, 1);
    base = n_wr;
    lb = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    send_line(1'b1, 999);
    check("basic_writes", n_wr - base, 2);

    // Odd byte count, then a fresh line: stray byte never pairs.
    base = n_wr;
    rand_bytes(5); send_line(1'b1, 999);
    lb = '{8'h12, 8'h34};
    send_line(1'b1, 999);
    check("odd_line_writes", n_wr - base, 3);

    // Row count now equals V: further lines are discarded.
    base = n_wr;
    rand_bytes(8); send_line(1'b1, 999);
    check("extra_line_dropped", n_wr - base, 0);
    frame_end();
    check("frame_done_once", n_fd, 1);
    check("overflow_clear", {31'd0, overflow}, 32'd0);

    // FIFO full while the second pixel completes.
    frame_begin();
    base = n_wr;
    rand_bytes(4); send_line(1'b1, 1);
    check("overflow_set", {31'd0, overflow}, {31'd0, m_ovf});
    fifo_full = 1'b0;
    tick(3);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    check("full_writes", n_wr - base, 1);

    // Overlong line: only H pixels written.
    base = n_wr;
    rand_bytes(12); send_line(1'b1, 999);
    check("h_limit_writes", n_wr - base, H);
`ifdef CAM_PACK_STATS_EN
    check("line_err_overlong", {31'd0, line_err}, 32'd1);
`endif
    frame_end();
    check("frame_done_twice", n_fd, 2);

    // Reset mid-line aborts the pending high byte.
    frame_begin();
    base = n_wr;
    lb = '{8'hAB};
    for (int i = 0; i < 1; i++) begin
      @(posedge clk); #1; cmos_href = 1'b1; cmos_db = lb[0];
    end
    lb.delete();
    tick(1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", {30'd0, state_dbg}, 32'd0);
    check("async_rst_overflow", {31'd0, overflow}, 32'd0);
    tick(2);
    rst = 1'b0;
    m_ovf = 1'b0;
    lb = '{8'hCD};
    send_line(1'b0, 999);
    check("rst_abort_writes", n_wr - base, 0);

`ifdef CAM_PACK_STATS_EN
    // Three complete frames: counters and error flag.
    do_reset();
    check("stats_rst_cnt", {16'd0, frame_cnt}, 32'd0);
    base = n_fd;
    for (int f = 0; f < 3; f++) begin
      frame_begin();
      for (int l = 0; l < V; l++) begin
        rand_bytes(2 * H); send_line(1'b1, 999);
      end
      frame_end();
    end
    check("stats_frame_done", n_fd - base, 3);
    check("stats_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    check("stats_line_err", {31'd0, line_err}, 32'd0);
`endif

    tick(4);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cam_pixel_packer.md
CAM_PIXEL_PACKER -- requirements
Module: cam_pixel_packer

Interface
REQ-001 The module SHALL have parameter H_PIXELS, default 640, meaning 16-bit pixels expected per HREF line.
REQ-002 The module SHALL have parameter V_LINES, default 480, meaning HREF lines expected per frame.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, driven by cmos_pclk, rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port cmos_vsync, input, 1 bit: frame sync, high between frames.
REQ-006 The module SHALL have port cmos_href, input, 1 bit: line-valid qualifier.
REQ-007 The module SHALL have port cmos_db, input, 8 bits: camera byte bus, high byte of RGB565 first.
REQ-008 The module SHALL have port fifo_full, input, 1 bit: downstream camera FIFO full.
REQ-009 The module SHALL have port wr_en, output, 1 bit: single-cycle FIFO write strobe.
REQ-010 The module SHALL have port wr_data, output, 16 bits: packed RGB565 pixel.
REQ-011 The module SHALL have port frame_start, output, 1 bit: one-cycle pulse on entry to CAPTURE.
REQ-012 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse on CAPTURE exit.
REQ-013 The module SHALL have port overflow, output, 1 bit: sticky flag, set when a pixel is dropped.

Function
REQ-014 cmos_vsync, cmos_href and cmos_db SHALL be registered once before use; all decisions use the registered copies.
REQ-015 The FSM SHALL have states WAIT_VS_HIGH, WAIT_VS_LOW and CAPTURE; after reset it enters WAIT_VS_HIGH.
REQ-016 WAIT_VS_HIGH -> WAIT_VS_LOW SHALL occur when registered vsync = 1; WAIT_VS_LOW -> CAPTURE when registered vsync = 0.
REQ-017 CAPTURE -> WAIT_VS_LOW SHALL occur when registered vsync rises; frame_done pulses that cycle.
REQ-018 A mid-frame start SHALL never be captured; a frame always begins after a full vsync high-to-low transition.
REQ-019 In CAPTURE, while registered href = 1, bytes SHALL alternate phases: phase 0 latches the high byte; phase 1 forms wr_data = {high, current}.
REQ-020 wr_en SHALL assert for one cycle, one cycle after the phase-1 byte is registered, only if fifo_full = 0 at that cycle.
REQ-021 If fifo_full = 1 when a pixel completes, the pixel SHALL be dropped, wr_en stays 0, and overflow is set until reset.
REQ-022 The byte phase SHALL reset to 0 on every href falling edge and on vsync; an odd trailing byte is discarded.
REQ-023 Pixels beyond H_PIXELS in a line, and lines beyond V_LINES in a frame, SHALL be discarded and never written.
REQ-024 Column counter width SHALL be clog2(H_PIXELS+1), row counter width clog2(V_LINES+1); both saturate and never wrap.
REQ-025 The row counter SHALL increment on href falling edge; both counters clear on CAPTURE entry.
REQ-026 Outside CAPTURE, wr_en SHALL be 0 regardless of href.

Reset
REQ-027 On rst = 1, asynchronously: state = WAIT_VS_HIGH, wr_en = 0, wr_data = 0, frame_start = 0, frame_done = 0, overflow = 0, counters = 0, phase = 0, input registers = 0.
REQ-028 Reset asserted mid-line SHALL abort the line; no partial pixel is written after release.

Configuration
REQ-029 Macro CAM_PACK_STATS_EN, when defined, SHALL add output frame_cnt (16 bits, increments on frame_done, wraps 0xFFFF -> 0) and output line_err (sticky; set when a line ends with column count != H_PIXELS or a frame ends with row count != V_LINES).
REQ-030 Without CAM_PACK_STATS_EN, neither port nor its logic SHALL exist; all other behaviour is identical.

Verification
REQ-031 Reset, vsync 1 -> 0, one line of 4 bytes 0xF8,0x00,0x07,0xE0 with href = 1 -> two wr_en pulses, data 0xF800 then 0x07E0; frame_start pulses once.
REQ-032 Release reset with vsync = 0 and href active -> no wr_en until vsync has gone 1 then 0.
REQ-033 fifo_full = 1 while the second pixel completes -> exactly one write (first pixel), overflow = 1 and stays 1 after fifo_full = 0.
REQ-034 H_PIXELS = 4, drive a line of 6 pixels -> exactly 4 writes; with CAM_PACK_STATS_EN, line_err = 1.
REQ-035 Odd byte count (5 bytes) per line, then a new line 0x12,0x34 -> writes of 2 pixels, then 0x1234; the stray byte is never paired.
REQ-036 With CAM_PACK_STATS_EN, 3 complete frames -> frame_done pulses 3 times, frame_cnt = 3, line_err = 0.
